// File: rtl/usb_buffer_pkg.sv
// Shared sizing and requester encoding for the USB data buffer.
// Used by the buffer controller, the AHB slave and the testbench.
package usb_buffer_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int OCC_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_RX_STORE,
        REQ_TX_GET,
        REQ_AHB_STORE,
        REQ_AHB_GET
    } t_buf_req;

    function automatic logic is_write_req(t_buf_req r);
        return (r == REQ_RX_STORE) || (r == REQ_AHB_STORE);
    endfunction

    function automatic logic is_read_req(t_buf_req r);
        return (r == REQ_TX_GET) || (r == REQ_AHB_GET);
    endfunction

endpackage

// File: rtl/buffer_ram.sv
// DEPTH x 8 register file with one synchronous write and one synchronous read port.
// The array is deliberately not reset; only the controller pointers define validity.
module buffer_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/usb_data_buffer_ctrl.sv
// Single-port FIFO controller for the shared USB data buffer: arbitrates four byte
// requesters (one grant per cycle), keeps pointers/occupancy and sticky error flags.
module usb_data_buffer_ctrl #(
    parameter int DEPTH  = usb_buffer_pkg::DEPTH,
    parameter int ADDR_W = usb_buffer_pkg::ADDR_W,
    parameter int OCC_W  = usb_buffer_pkg::OCC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             store_tx_data,
    input  logic [7:0]       tx_data,
    input  logic             get_rx_data,
    output logic [7:0]       rx_data,
    output logic             rx_data_valid,
    input  logic             rx_store,
    input  logic [7:0]       rx_store_data,
    input  logic             tx_get,
    output logic [7:0]       tx_get_data,
    output logic             tx_get_valid,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             req_drop
);
    import usb_buffer_pkg::*;

    logic             rs_pend, tg_pend, st_pend, gr_pend;
    logic [7:0]       rs_hold, st_hold;
    t_buf_req         grant;
    logic             is_wr, is_rd, wr_go, rd_go;
    logic [7:0]       wr_data, ram_q, rd_val;
    logic [ADDR_W-1:0] wptr, rptr;
    logic [OCC_W-1:0] occ_nxt;
    logic             rx_vld_q, tx_vld_q, rd_empty_q;
    logic [7:0]       rx_hold_q, tx_hold_q;

    // Fixed priority, USB side first; clear swallows every request in its cycle.
    always_comb begin
        grant = REQ_NONE;
        if (!clear) begin
            if (rx_store || rs_pend)           grant = REQ_RX_STORE;
            else if (tx_get || tg_pend)        grant = REQ_TX_GET;
            else if (store_tx_data || st_pend) grant = REQ_AHB_STORE;
            else if (get_rx_data || gr_pend)   grant = REQ_AHB_GET;
        end
        is_wr   = is_write_req(grant);
        is_rd   = is_read_req(grant);
        wr_go   = is_wr && !full;
        rd_go   = is_rd && !empty;
        wr_data = (grant == REQ_RX_STORE) ? (rs_pend ? rs_hold : rx_store_data)
                                          : (st_pend ? st_hold : tx_data);
        occ_nxt = buffer_occupancy + OCC_W'(wr_go) - OCC_W'(rd_go);
    end

    buffer_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_go),
        .waddr (wptr),
        .wdata (wr_data),
        .re    (rd_go),
        .raddr (rptr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0; rptr <= '0; buffer_occupancy <= '0;
            empty <= 1'b1; full <= 1'b0;
            overflow <= 1'b0; underflow <= 1'b0; req_drop <= 1'b0;
            rs_pend <= 1'b0; tg_pend <= 1'b0; st_pend <= 1'b0; gr_pend <= 1'b0;
            rs_hold <= '0; st_hold <= '0;
        end else if (clear) begin
            wptr <= '0; rptr <= '0; buffer_occupancy <= '0;
            empty <= 1'b1; full <= 1'b0;
            overflow <= 1'b0; underflow <= 1'b0; req_drop <= 1'b0;
            rs_pend <= 1'b0; tg_pend <= 1'b0; st_pend <= 1'b0; gr_pend <= 1'b0;
        end else begin
            if (wr_go) wptr <= wptr + 1'b1;
            if (rd_go) rptr <= rptr + 1'b1;
            buffer_occupancy <= occ_nxt;
            empty <= (occ_nxt == '0);
            full  <= (occ_nxt == OCC_W'(DEPTH));
            overflow  <= overflow  | (is_wr && full);
            underflow <= underflow | (is_rd && empty);
            // A repeat pulse while still pending is discarded; the original stays queued.
            req_drop <= req_drop | (rx_store && rs_pend) | (tx_get && tg_pend)
                                 | (store_tx_data && st_pend) | (get_rx_data && gr_pend);
            rs_pend <= (grant == REQ_RX_STORE)  ? 1'b0 : (rs_pend | rx_store);
            tg_pend <= (grant == REQ_TX_GET)    ? 1'b0 : (tg_pend | tx_get);
            st_pend <= (grant == REQ_AHB_STORE) ? 1'b0 : (st_pend | store_tx_data);
            gr_pend <= (grant == REQ_AHB_GET)   ? 1'b0 : (gr_pend | get_rx_data);
            if (rx_store && !rs_pend && grant != REQ_RX_STORE)
                rs_hold <= rx_store_data;
            if (store_tx_data && !st_pend && grant != REQ_AHB_STORE)
                st_hold <= tx_data;
        end
    end

    // Read results land one cycle after the grant; empty reads return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_vld_q   <= 1'b0;
            tx_vld_q   <= 1'b0;
            rd_empty_q <= 1'b0;
            rx_hold_q  <= '0;
            tx_hold_q  <= '0;
        end else begin
            rx_vld_q  <= (grant == REQ_AHB_GET);
            tx_vld_q  <= (grant == REQ_TX_GET);
            if (is_rd) rd_empty_q <= empty;
            rx_hold_q <= rx_data;
            tx_hold_q <= tx_get_data;
        end
    end

    assign rd_val        = rd_empty_q ? 8'h00 : ram_q;
    assign rx_data       = rx_vld_q ? rd_val : rx_hold_q;
    assign tx_get_data   = tx_vld_q ? rd_val : tx_hold_q;
    assign rx_data_valid = rx_vld_q;
    assign tx_get_valid  = tx_vld_q;

endmodule

// File: tb/tb_usb_data_buffer_ctrl.sv
// Directed bench for usb_data_buffer_ctrl: FIFO model plus per-reader scoreboards.
module tb_usb_data_buffer_ctrl;
    import usb_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst, clear, store_tx_data, get_rx_data, rx_store, tx_get;
    logic [7:0] tx_data, rx_store_data, rx_data, tx_get_data;
    logic rx_data_valid, tx_get_valid, empty, full, overflow, underflow, req_drop;
    logic [OCC_W-1:0] buffer_occupancy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int occ_max = 0;
    bit track = 1'b0;
    logic [7:0] mq[$];
    logic [8:0] rx_exp[$];
    logic [8:0] tx_exp[$];

    usb_data_buffer_ctrl dut (
        .clk(clk), .rst(rst), .clear(clear),
        .store_tx_data(store_tx_data), .tx_data(tx_data),
        .get_rx_data(get_rx_data), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_store(rx_store), .rx_store_data(rx_store_data),
        .tx_get(tx_get), .tx_get_data(tx_get_data), .tx_get_valid(tx_get_valid),
        .buffer_occupancy(buffer_occupancy), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow), .req_drop(req_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: every read result is popped against the value queued at request time.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rx_data_valid) begin
            e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 9'h1FF;
            total_cnt++;
            assert ({1'b0, rx_data} === e) pass_cnt++;
            else $error("FAIL sb_rx_data: observed %0h expected %0h", rx_data, e);
        end
        if (tx_get_valid) begin
            e = (tx_exp.size() > 0) ? tx_exp.pop_front() : 9'h1FF;
            total_cnt++;
            assert ({1'b0, tx_get_data} === e) pass_cnt++;
            else $error("FAIL sb_tx_data: observed %0h expected %0h", tx_get_data, e);
        end
        if (track && int'(buffer_occupancy) > occ_max) occ_max = int'(buffer_occupancy);
    end

    task automatic drive(input bit rs, input logic [7:0] rsd, input bit tg,
                         input bit st, input logic [7:0] std, input bit gr);
        rx_store = rs; rx_store_data = rsd; tx_get = tg;
        store_tx_data = st; tx_data = std; get_rx_data = gr;
        @(posedge clk); #1;
        rx_store = 1'b0; tx_get = 1'b0; store_tx_data = 1'b0; get_rx_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_rx(input logic [7:0] d);
        if (mq.size() < DEPTH) mq.push_back(d);
        drive(1'b1, d, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wr_ahb(input logic [7:0] d);
        if (mq.size() < DEPTH) mq.push_back(d);
        drive(1'b0, 8'h00, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic rd_ahb();
        rx_exp.push_back((mq.size() > 0) ? {1'b0, mq.pop_front()} : 9'h000);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic rd_tx();
        tx_exp.push_back((mq.size() > 0) ? {1'b0, mq.pop_front()} : 9'h000);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mq.delete();
        #2;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        rx_store = 1'b0; tx_get = 1'b0; store_tx_data = 1'b0; get_rx_data = 1'b0;
        rx_store_data = 8'h00; tx_data = 8'h00;
        #12;
        chk("rst_occ", 32'(buffer_occupancy), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_data", {16'h0, rx_data, tx_get_data}, 0);
        chk("rst_valids", {30'h0, rx_data_valid, tx_get_valid}, 0);
        chk("rst_flags", {29'h0, overflow, underflow, req_drop}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill, overflow, drain, underflow
        for (int i = 0; i < DEPTH; i++) wr_rx(8'(i));
        chk("fill_occ", 32'(buffer_occupancy), 64);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf_clear", 32'(overflow), 0);
        wr_rx(8'hAA);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_occ", 32'(buffer_occupancy), 64);
        for (int i = 0; i < DEPTH; i++) rd_ahb();
        idle(1);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_occ", 32'(buffer_occupancy), 0);
        rd_ahb();
        idle(1);
        chk("udf_flag", 32'(underflow), 1);
        chk("udf_data", 32'(rx_data), 0);

        // All four requesters in one cycle with one byte (0x55) resident
        do_reset();
        wr_rx(8'h55);
        tx_exp.push_back(9'h055);
        rx_exp.push_back(9'h011);
        drive(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1);
        chk("sim_g1_occ", 32'(buffer_occupancy), 2);
        idle(1);
        chk("sim_g2_occ", 32'(buffer_occupancy), 1);
        chk("sim_g2_txv", 32'(tx_get_valid), 1);
        chk("sim_g2_txd", 32'(tx_get_data), 32'h55);
        idle(1);
        chk("sim_g3_occ", 32'(buffer_occupancy), 2);
        chk("sim_g3_rxv", 32'(rx_data_valid), 0);
        idle(1);
        chk("sim_g4_occ", 32'(buffer_occupancy), 1);
        chk("sim_g4_rxv", 32'(rx_data_valid), 1);
        chk("sim_g4_rxd", 32'(rx_data), 32'h11);
        idle(1);
        chk("sim_end_occ", 32'(buffer_occupancy), 1);

        // Pending collision: the second AHB store is dropped
        do_reset();
        mq.push_back(8'h01);
        drive(1'b1, 8'h01, 1'b0, 1'b1, 8'h33, 1'b0);
        chk("pend_nodrop", 32'(req_drop), 0);
        mq.push_back(8'h02);
        drive(1'b1, 8'h02, 1'b0, 1'b1, 8'h44, 1'b0);
        chk("pend_drop", 32'(req_drop), 1);
        idle(1);
        mq.push_back(8'h33);
        chk("pend_occ", 32'(buffer_occupancy), 3);
        for (int i = 0; i < 3; i++) rd_ahb();
        idle(1);
        chk("pend_drain", 32'(buffer_occupancy), 0);

        // Wrap-around across the 63->0 pointer boundary
        do_reset();
        occ_max = 0; track = 1'b1;
        for (int i = 0; i < 40; i++) wr_ahb(8'(i + 8'h40));
        for (int i = 0; i < 40; i++) rd_ahb();
        for (int i = 0; i < 40; i++) wr_rx(8'(i) ^ 8'hC3);
        for (int i = 0; i < 40; i++) rd_tx();
        idle(1);
        track = 1'b0;
        chk("wrap_max_occ", 32'(occ_max), 40);
        chk("wrap_empty", 32'(empty), 1);

        // Clear with occupancy 10, tx_get pending and a same-cycle AHB store
        do_reset();
        rd_ahb();
        idle(1);
        chk("clr_pre_udf", 32'(underflow), 1);
        for (int i = 0; i < 9; i++) wr_ahb(8'(i + 8'h90));
        mq.push_back(8'h77);
        drive(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("clr_pre_occ", 32'(buffer_occupancy), 10);
        clear = 1'b1; store_tx_data = 1'b1; tx_data = 8'h99;
        @(posedge clk); #1;
        clear = 1'b0; store_tx_data = 1'b0;
        mq.delete();
        chk("clr_occ", 32'(buffer_occupancy), 0);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_flags", {29'h0, overflow, underflow, req_drop}, 0);
        chk("clr_txv", 32'(tx_get_valid), 0);
        idle(3);
        chk("clr_occ_hold", 32'(buffer_occupancy), 0);
        wr_ahb(8'h5A);
        rd_ahb();
        idle(1);
        chk("clr_reuse_occ", 32'(buffer_occupancy), 0);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 5; i++) wr_rx(8'(i + 8'hE0));
        rd_ahb();
        rd_ahb();
        chk("mid_valid_pre", 32'(rx_data_valid), 1);
        #1 rst = 1'b1;
        #1;
        void'(rx_exp.pop_back());
        mq.delete();
        chk("mid_rst_valid", 32'(rx_data_valid), 0);
        chk("mid_rst_data", 32'(rx_data), 0);
        chk("mid_rst_occ", 32'(buffer_occupancy), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        chk("sb_rx_leftover", 32'(rx_exp.size()), 0);
        chk("sb_tx_leftover", 32'(tx_exp.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
